// File: rtl/hd44780_refresh_sequencer_if.sv
// hd44780_refresh_sequencer_if
//   Bundles the formatter request lines and the LCD control pins that the
//   refresh sequencer drives.
//   Members:
//     o_ena    formatter enable, one-cycle pulse per item
//     o_data   formatter mode: 1 = character, 0 = command/address
//     o_sel    formatter select
//     o_d      formatter digit/address nibble
//     o_lcd_rs LCD RS pin
//     o_lcd_e  LCD E pin
//   Modports: master (sequencer side, drives everything), slave (formatter/pins).
interface hd44780_refresh_sequencer_if;
  logic       o_ena;
  logic       o_data;
  logic [2:0] o_sel;
  logic [3:0] o_d;
  logic       o_lcd_rs;
  logic       o_lcd_e;

  modport master (output o_ena, o_data, o_sel, o_d, o_lcd_rs, o_lcd_e);
  modport slave  (input  o_ena, o_data, o_sel, o_d, o_lcd_rs, o_lcd_e);
endinterface

// File: rtl/hd44780_refresh_sequencer.sv
// hd44780_refresh_sequencer
//   Drives the HD44780 formatter and LCD strobes for the clock display:
//   power-up wait, four-command init (0x38, 0x0C, 0x01, 0x06), then repaints
//   line 0 with "HH:MM:SS AM/PM" on every refresh request. Owns all LCD
//   timing: RS/data setup, E pulse width and command execution waits.
//   Optional feature macro: HD44780_SEQ_SECONDS_EN
//     defined   -> 11 characters "HH:MM:SS AM"
//     undefined -> 8 characters "HH:MM AM", seconds inputs ignored
//   Ports:
//     i_clk, i_rst        clock, synchronous active-high reset
//     i_start             refresh request pulse (coalesced if busy)
//     i_hr_t..i_sec_o     BCD time digits, i_pm = PM flag
//     fmt (master)        formatter request + LCD RS/E pins
//     o_busy              high whenever not idle
//     o_init_done         sticky once init sequence completes
module hd44780_refresh_sequencer #(
  parameter int POWERUP_CYC  = 2000000,
  parameter int SETUP_CYC    = 4,
  parameter int E_PULSE_CYC  = 50,
  parameter int CMD_WAIT_CYC = 5000,
  parameter int CLR_WAIT_CYC = 200000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [3:0] i_hr_t,
  input  logic [3:0] i_hr_o,
  input  logic [3:0] i_min_t,
  input  logic [3:0] i_min_o,
  input  logic [3:0] i_sec_t,
  input  logic [3:0] i_sec_o,
  input  logic       i_pm,
  hd44780_refresh_sequencer_if.master fmt,
  output logic       o_busy,
  output logic       o_init_done
);

  // A zero-length phase still occupies one cycle.
  localparam int PWR_E = (POWERUP_CYC  < 1) ? 1 : POWERUP_CYC;
  localparam int SET_E = (SETUP_CYC    < 1) ? 1 : SETUP_CYC;
  localparam int EHI_E = (E_PULSE_CYC  < 1) ? 1 : E_PULSE_CYC;
  localparam int CMD_E = (CMD_WAIT_CYC < 1) ? 1 : CMD_WAIT_CYC;
  localparam int CLR_E = (CLR_WAIT_CYC < 1) ? 1 : CLR_WAIT_CYC;

  localparam int MX1 = (PWR_E > SET_E) ? PWR_E : SET_E;
  localparam int MX2 = (MX1 > EHI_E) ? MX1 : EHI_E;
  localparam int MX3 = (MX2 > CMD_E) ? MX2 : CMD_E;
  localparam int MXP = (MX3 > CLR_E) ? MX3 : CLR_E;
  localparam int CW  = $clog2(MXP + 1);

  localparam logic [CW-1:0] PWR_M1 = CW'(PWR_E - 1);
  localparam logic [CW-1:0] SET_M1 = CW'(SET_E - 1);
  localparam logic [CW-1:0] EHI_M1 = CW'(EHI_E - 1);
  localparam logic [CW-1:0] CMD_M1 = CW'(CMD_E - 1);
  localparam logic [CW-1:0] CLR_M1 = CW'(CLR_E - 1);

`ifdef HD44780_SEQ_SECONDS_EN
  localparam logic [3:0] LAST_REF = 4'd11;
`else
  localparam logic [3:0] LAST_REF = 4'd8;
`endif
  localparam logic [3:0] LAST_INIT = 4'd3;

  typedef enum logic [1:0] {S_POWERUP, S_INIT, S_IDLE, S_REFRESH} state_t;
  typedef enum logic [1:0] {P_ISSUE, P_SETUP, P_EHIGH, P_WAIT} phase_t;

  state_t        state, state_n;
  phase_t        phase, phase_n;
  logic [3:0]    idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          pend, init_done, rs_q;
  logic [CW-1:0] wait_m1;
  logic          active, enter_ref, init_fin;

  // Time snapshot, frozen for the whole refresh.
  logic [3:0] s_hr_t, s_hr_o, s_min_t, s_min_o;
  logic       s_pm;
`ifdef HD44780_SEQ_SECONDS_EN
  logic [3:0] s_sec_t, s_sec_o;
`else
  logic       unused_sec;
  assign unused_sec = ^{i_sec_t, i_sec_o};
`endif

  logic       item_data;
  logic [2:0] item_sel;
  logic [3:0] item_d;

  assign active    = (state == S_INIT) || (state == S_REFRESH);
  assign enter_ref = (state != S_REFRESH) && (state_n == S_REFRESH);
  assign init_fin  = (state == S_INIT) && (state_n == S_IDLE);
  // Only the third init command (0x01, Display Clear) needs the long wait.
  assign wait_m1   = (state == S_INIT && idx == 4'd2) ? CLR_M1 : CMD_M1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_POWERUP;
      phase     <= P_ISSUE;
      idx       <= '0;
      cnt       <= '0;
      pend      <= 1'b0;
      init_done <= 1'b0;
      rs_q      <= 1'b0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      if (enter_ref)
        pend <= 1'b0;
      else if (i_start && state != S_IDLE)
        pend <= 1'b1;
      if (init_fin)
        init_done <= 1'b1;
      if (fmt.o_ena)
        rs_q <= item_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s_hr_t  <= '0;
      s_hr_o  <= '0;
      s_min_t <= '0;
      s_min_o <= '0;
      s_pm    <= 1'b0;
`ifdef HD44780_SEQ_SECONDS_EN
      s_sec_t <= '0;
      s_sec_o <= '0;
`endif
    end else if (enter_ref) begin
      s_hr_t  <= i_hr_t;
      s_hr_o  <= i_hr_o;
      s_min_t <= i_min_t;
      s_min_o <= i_min_o;
      s_pm    <= i_pm;
`ifdef HD44780_SEQ_SECONDS_EN
      s_sec_t <= i_sec_t;
      s_sec_o <= i_sec_o;
`endif
    end
  end

  always_comb begin
    state_n = state;
    phase_n = phase;
    idx_n   = idx;
    cnt_n   = cnt + CW'(1);
    case (state)
      S_POWERUP: begin
        if (cnt == PWR_M1) begin
          state_n = S_INIT;
          phase_n = P_ISSUE;
          idx_n   = '0;
          cnt_n   = '0;
        end
      end
      S_INIT, S_REFRESH: begin
        case (phase)
          P_ISSUE: begin
            phase_n = P_SETUP;
            cnt_n   = '0;
          end
          P_SETUP: begin
            if (cnt == SET_M1) begin
              phase_n = P_EHIGH;
              cnt_n   = '0;
            end
          end
          P_EHIGH: begin
            if (cnt == EHI_M1) begin
              phase_n = P_WAIT;
              cnt_n   = '0;
            end
          end
          default: begin
            if (cnt == wait_m1) begin
              cnt_n   = '0;
              phase_n = P_ISSUE;
              if (idx == ((state == S_INIT) ? LAST_INIT : LAST_REF))
                state_n = S_IDLE;
              else
                idx_n = idx + 4'd1;
            end
          end
        endcase
      end
      default: begin
        // IDLE: a live request or one parked while busy starts a repaint.
        cnt_n = '0;
        if (i_start || pend) begin
          state_n = S_REFRESH;
          phase_n = P_ISSUE;
          idx_n   = '0;
        end
      end
    endcase
  end

  // Item content is a pure function of (state, idx), so it stays stable
  // from ISSUE through the end of WAIT.
  always_comb begin
    item_data = 1'b0;
    item_sel  = 3'b000;
    item_d    = 4'd0;
    if (state == S_INIT) begin
      item_sel = {1'b1, idx[1:0]};
    end else if (state == S_REFRESH) begin
      item_data = (idx != 4'd0);
      case (idx)
        4'd1: item_d = s_hr_t;
        4'd2: item_d = s_hr_o;
        4'd3: item_sel = 3'b001;
        4'd4: item_d = s_min_t;
        4'd5: item_d = s_min_o;
`ifdef HD44780_SEQ_SECONDS_EN
        4'd6: item_sel = 3'b001;
        4'd7: item_d = s_sec_t;
        4'd8: item_d = s_sec_o;
        4'd9: begin item_sel = 3'b001; item_d = 4'd1; end
        4'd10: begin item_sel = 3'b011; item_d = {3'b000, s_pm}; end
        4'd11: item_sel = 3'b010;
`else
        4'd6: begin item_sel = 3'b001; item_d = 4'd1; end
        4'd7: begin item_sel = 3'b011; item_d = {3'b000, s_pm}; end
        4'd8: item_sel = 3'b010;
`endif
        default: ;
      endcase
    end
  end

  assign fmt.o_ena    = active && (phase == P_ISSUE);
  assign fmt.o_data   = item_data;
  assign fmt.o_sel    = item_sel;
  assign fmt.o_d      = item_d;
  assign fmt.o_lcd_rs = rs_q;
  assign fmt.o_lcd_e  = active && (phase == P_EHIGH);
  assign o_busy       = (state != S_IDLE);
  assign o_init_done  = init_done;

endmodule

// File: tb/tb_hd44780_refresh_sequencer.sv
module tb_hd44780_refresh_sequencer;
  // POWERUP=10, SETUP=2, E=3, CMD=5, CLR=20 -> normal item 11 cycles, clear 26.
  localparam int ITEM = 11;
`ifdef HD44780_SEQ_SECONDS_EN
  localparam int NREF = 12;
  // {data, sel[2:0], d[3:0]} for address + "12:34:56 PM"
  logic [7:0] exp_1234 [12] = '{8'h00, 8'h81, 8'h82, 8'h90, 8'h83, 8'h84,
                                8'h90, 8'h85, 8'h86, 8'h91, 8'hB1, 8'hA0};
  // address + "09:45:17 AM"
  logic [7:0] exp_0945 [12] = '{8'h00, 8'h80, 8'h89, 8'h90, 8'h84, 8'h85,
                                8'h90, 8'h81, 8'h87, 8'h91, 8'hB0, 8'hA0};
`else
  localparam int NREF = 9;
  logic [7:0] exp_1234 [9] = '{8'h00, 8'h81, 8'h82, 8'h90, 8'h83, 8'h84,
                               8'h91, 8'hB1, 8'hA0};
  logic [7:0] exp_0945 [9] = '{8'h00, 8'h80, 8'h89, 8'h90, 8'h84, 8'h85,
                               8'h91, 8'hB0, 8'hA0};
`endif
  logic [7:0] exp_init [4] = '{8'h40, 8'h50, 8'h60, 8'h70};
  int         init_ofs [4] = '{10, 21, 32, 58};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] hr_t = 0, hr_o = 0, min_t = 0, min_o = 0, sec_t = 0, sec_o = 0;
  logic       pm = 1'b0;
  logic       busy, init_done;

  hd44780_refresh_sequencer_if fmt ();

  hd44780_refresh_sequencer #(
    .POWERUP_CYC(10), .SETUP_CYC(2), .E_PULSE_CYC(3),
    .CMD_WAIT_CYC(5), .CLR_WAIT_CYC(20)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_hr_t(hr_t), .i_hr_o(hr_o), .i_min_t(min_t), .i_min_o(min_o),
    .i_sec_t(sec_t), .i_sec_o(sec_o), .i_pm(pm),
    .fmt(fmt), .o_busy(busy), .o_init_done(init_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_mis = 0, rel;
  logic [7:0] ev_item [$];
  int         ev_cyc  [$];
  logic       ev_rs   [$];
  int         bfall   [$];
  int         done_rise;

  task automatic set_time(input logic [3:0] a, b, c, d, e, f, input logic p);
    hr_t = a; hr_o = b; min_t = c; min_o = d; sec_t = e; sec_o = f; pm = p;
  endtask

  task automatic observe(input int ncyc);
    logic pe, pb, pd;
    ev_item.delete(); ev_cyc.delete(); ev_rs.delete(); bfall.delete();
    done_rise = -1;
    pe = fmt.o_lcd_e; pb = busy; pd = init_done;
    repeat (ncyc) begin
      @(negedge clk);
      if (fmt.o_ena) begin
        ev_item.push_back({fmt.o_data, fmt.o_sel, fmt.o_d});
        ev_cyc.push_back(cyc);
      end
      if (fmt.o_lcd_e && !pe) ev_rs.push_back(fmt.o_lcd_rs);
      if (pb && !busy) bfall.push_back(cyc);
      if (!pd && init_done && done_rise < 0) done_rise = cyc;
      pe = fmt.o_lcd_e; pb = busy; pd = init_done;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rel = cyc;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] got;
    do_reset();
    got = {fmt.o_ena, fmt.o_data, fmt.o_sel, fmt.o_d, fmt.o_lcd_rs, fmt.o_lcd_e};
    n_cmp++;
    if (got !== 10'd0) begin
      n_mis++; $display("FAIL reset_outputs got=%b want=0", got);
    end
    n_cmp++;
    if (init_done !== 1'b0) begin
      n_mis++; $display("FAIL reset_init_done got=%b want=0", init_done);
    end
  endtask

  task automatic test_init();
    logic [7:0] it;
    int c;
    observe(75);
    n_cmp++;
    if (ev_item.size() != 4) begin
      n_mis++; $display("FAIL init_count got=%0d want=4", ev_item.size());
    end
    for (int i = 0; i < 4; i++) begin
      it = (i < ev_item.size()) ? ev_item[i] : 8'hxx;
      c  = (i < ev_cyc.size()) ? ev_cyc[i] - rel : -1;
      n_cmp++;
      if (it !== exp_init[i]) begin
        n_mis++; $display("FAIL init_item%0d got=%h want=%h", i, it, exp_init[i]);
      end
      n_cmp++;
      if (c != init_ofs[i]) begin
        n_mis++; $display("FAIL init_time%0d got=%0d want=%0d", i, c, init_ofs[i]);
      end
    end
    n_cmp++;
    if (done_rise - rel != 69) begin
      n_mis++; $display("FAIL init_done_time got=%0d want=69", done_rise - rel);
    end
    n_cmp++;
    if (ev_rs.size() != 4 || ev_rs.sum() != 0) begin
      n_mis++; $display("FAIL init_rs got_n=%0d got_sum=%0d want 4/0", ev_rs.size(), ev_rs.sum());
    end
  endtask

  // Check one refresh stream starting at queue offset base.
  task automatic check_stream(input string nm, input int base, input logic [7:0] exp [NREF],
                              input int first_cyc);
    logic [7:0] it;
    int c;
    for (int i = 0; i < NREF; i++) begin
      it = (base + i < ev_item.size()) ? ev_item[base + i] : 8'hxx;
      c  = (base + i < ev_cyc.size()) ? ev_cyc[base + i] : -1;
      n_cmp++;
      if (it !== exp[i]) begin
        n_mis++; $display("FAIL %s_item%0d got=%h want=%h", nm, i, it, exp[i]);
      end
      n_cmp++;
      if (c != first_cyc + ITEM * i) begin
        n_mis++; $display("FAIL %s_time%0d got=%0d want=%0d", nm, i, c, first_cyc + ITEM * i);
      end
    end
  endtask

  task automatic test_refresh_snapshot();
    int s;
    logic rsx;
    set_time(1, 2, 3, 4, 5, 6, 1);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_mis++; $display("FAIL idle_busy got=%b want=0", busy);
    end
    s = cyc;
    fork
      begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        set_time(0, 1, 0, 0, 0, 0, 0);   // changes after refresh began
      end
      observe(NREF * ITEM + 10);
    join
    n_cmp++;
    if (ev_item.size() != NREF) begin
      n_mis++; $display("FAIL ref_count got=%0d want=%0d", ev_item.size(), NREF);
    end
    check_stream("ref", 0, exp_1234, s + 1);
    n_cmp++;
    if (ev_rs.size() != NREF) begin
      n_mis++; $display("FAIL ref_rs_n got=%0d want=%0d", ev_rs.size(), NREF);
    end
    for (int i = 0; i < NREF; i++) begin
      rsx = (i < ev_rs.size()) ? ev_rs[i] : 1'bx;
      n_cmp++;
      if (rsx !== (i != 0)) begin
        n_mis++; $display("FAIL ref_rs%0d got=%b want=%b", i, rsx, (i != 0));
      end
    end
    n_cmp++;
    if (bfall.size() != 1 || bfall[0] != s + 1 + NREF * ITEM) begin
      n_mis++; $display("FAIL ref_busy_fall got_n=%0d want at %0d", bfall.size(), s + 1 + NREF * ITEM);
    end
  endtask

  task automatic test_back_to_back();
    int s;
    set_time(1, 2, 3, 4, 5, 6, 1);
    s = cyc;
    fork
      begin
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (20) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (40) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
      end
      observe(2 * NREF * ITEM + 30);
    join
    n_cmp++;
    if (ev_item.size() != 2 * NREF) begin
      n_mis++; $display("FAIL b2b_count got=%0d want=%0d", ev_item.size(), 2 * NREF);
    end
    n_cmp++;
    if (bfall.size() != 2) begin
      n_mis++; $display("FAIL b2b_busy_falls got=%0d want=2", bfall.size());
    end
    check_stream("b2b_a", 0, exp_1234, s + 1);
    // second repaint starts the cycle after the one idle cycle
    check_stream("b2b_b", NREF, exp_1234, s + 2 + NREF * ITEM);
  endtask

  task automatic test_hm_am();
    int s;
    set_time(0, 9, 4, 5, 1, 7, 0);
    s = cyc;
    fork
      begin start = 1'b1; @(negedge clk); start = 1'b0; end
      observe(NREF * ITEM + 10);
    join
    n_cmp++;
    if (ev_item.size() != NREF) begin
      n_mis++; $display("FAIL hm_count got=%0d want=%0d", ev_item.size(), NREF);
    end
    check_stream("hm", 0, exp_0945, s + 1);
  endtask

  task automatic test_reset_mid_e();
    int t = 0;
    set_time(1, 2, 3, 4, 5, 6, 1);
    start = 1'b1; @(negedge clk); start = 1'b0;
    while (!fmt.o_lcd_e && t < 40) begin @(negedge clk); t++; end
    n_cmp++;
    if (!fmt.o_lcd_e) begin
      n_mis++; $display("FAIL mid_e_wait got=timeout want=E high");
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (fmt.o_lcd_e !== 1'b0 || init_done !== 1'b0 || fmt.o_ena !== 1'b0) begin
      n_mis++; $display("FAIL mid_e_reset got e=%b done=%b ena=%b want 0/0/0",
                        fmt.o_lcd_e, init_done, fmt.o_ena);
    end
    do_reset();
    test_init();
  endtask

  task automatic test_pending_powerup();
    set_time(1, 2, 3, 4, 5, 6, 1);
    do_reset();
    fork
      begin @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0; end
      observe(70 + NREF * ITEM + 15);
    join
    n_cmp++;
    if (ev_item.size() != 4 + NREF) begin
      n_mis++; $display("FAIL pend_count got=%0d want=%0d", ev_item.size(), 4 + NREF);
    end
    check_stream("pend", 4, exp_1234, rel + 70);
  endtask

  initial begin
    test_reset();
    test_init();
    test_refresh_snapshot();
    test_back_to_back();
    test_hm_am();
    test_reset_mid_e();
    test_pending_powerup();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/hd44780_refresh_sequencer.md
Name: hd44780_refresh_sequencer

Overview:
Sequences the HD44780 data-output formatter and the LCD control strobes for the clock display. After power-up it issues the four-command init sequence, then repaints line 0 with "HH:MM:SS AM/PM" on each refresh request. It sits between the timekeeping counters and the formatter/LCD pins and owns all HD44780 timing: setup, E pulse width and command execution waits.

Parameters:
POWERUP_CYC, 2000000, cycles to wait after reset before the first command (20 ms at 100 MHz)
SETUP_CYC, 4, cycles from formatter enable to E rising (covers the formatter's 1-cycle latency plus RS/data setup)
E_PULSE_CYC, 50, cycles E is held high (500 ns)
CMD_WAIT_CYC, 5000, cycles after E falls for a normal command or character (50 us)
CLR_WAIT_CYC, 200000, cycles after E falls for Display Clear (2 ms)

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous reset, active-high
i_start  in  1  refresh request pulse; repaint line 0
i_hr_t  in  4  hours tens digit (BCD)
i_hr_o  in  4  hours ones digit
i_min_t  in  4  minutes tens
i_min_o  in  4  minutes ones
i_sec_t  in  4  seconds tens
i_sec_o  in  4  seconds ones
i_pm  in  1  1 = PM, 0 = AM
o_ena  out  1  formatter enable, 1-cycle pulse per item
o_data  out  1  formatter mode: 1 = character, 0 = command/address
o_sel  out  3  formatter select
o_d  out  4  formatter digit/address nibble
o_lcd_rs  out  1  LCD RS pin
o_lcd_e  out  1  LCD E pin
o_busy  out  1  high whenever not in IDLE
o_init_done  out  1  sticky high once init completes

Behaviour:
- Reset (sync, i_rst high at a rising edge): state POWERUP, counter cleared, pending cleared; all outputs 0 (o_lcd_e 0 from the next edge, even mid-pulse).
- Main FSM: POWERUP -> INIT -> IDLE -> REFRESH -> IDLE.
- POWERUP: count POWERUP_CYC cycles, then enter INIT.
- INIT: four commands, each o_data=0, o_sel=3'b100, 101, 110, 111 (0x38, 0x0C, 0x01, 0x06). Then set o_init_done=1 and enter IDLE.
- REFRESH: first item is address o_data=0, o_sel=3'b000, o_d=0 (DDRAM 0x80). Then 11 characters, all o_data=1:
  - hr_t, hr_o: o_sel=000, o_d=digit
  - ':': sel=001, d=0
  - min_t, min_o: sel=000, d=digit
  - ':': sel=001, d=0
  - sec_t, sec_o: sel=000, d=digit
  - ' ': sel=001, d=1
  - 'A'/'P': sel=011, d={3'b0,pm}
  - 'M': sel=010, d=0
- Item strobe sub-sequence, used for every item:
  - ISSUE: o_ena=1 for exactly one cycle; o_data/o_sel/o_d valid that cycle and held until the item ends.
  - SETUP: SETUP_CYC cycles; o_lcd_rs=o_data, registered at ISSUE.
  - EHIGH: o_lcd_e=1 for E_PULSE_CYC cycles.
  - WAIT: o_lcd_e=0 for CMD_WAIT_CYC cycles, or CLR_WAIT_CYC for the 0x01 command.
  - Next item's ISSUE follows on the next cycle.
- Snapshot: all time inputs are captured into internal registers on the cycle REFRESH is entered. Input changes during a refresh do not affect that refresh.
- i_start in IDLE (init done): enter REFRESH next cycle.
- i_start during POWERUP, INIT or REFRESH: set pending. Multiple requests coalesce into one. On return to IDLE with pending set, clear pending and enter REFRESH immediately.
- Counters sized for the largest parameter; a count of 0 is treated as 1 cycle.
- Digit inputs > 9 are passed through unchecked.

Optional Feature:
Macro HD44780_SEQ_SECONDS_EN.
- Defined: full 11-character sequence as above.
- Undefined: the second ':' and the two seconds characters are omitted, giving 8 characters "HH:MM AM". i_sec_t/i_sec_o are ignored and their snapshot registers are not built.

Test Plan:
1. Reset release with small parameters (POWERUP=10, SETUP=2, E=3, CMD=5, CLR=20) -> four o_ena pulses with sel 4,5,6,7 and data=0. Gap after sel=6 is 20 wait cycles; o_init_done rises after the last wait.
2. After init, i_start with 12:34:56 PM -> address item (sel=0, d=0, RS=0), then 11 chars; RS=1 on each E; sel/d stream matches 1,2,':',3,4,':',5,6,' ',P,M; o_busy falls after the last wait.
3. Time inputs changed to 01:00:00 AM one cycle after the start of test 2's refresh -> the output stream still shows 12:34:56 PM.
4. Three i_start pulses during a refresh -> exactly one additional refresh, starting the cycle after return to IDLE.
5. i_rst asserted while o_lcd_e=1 -> E low next cycle, o_init_done=0, full POWERUP/INIT repeats.
6. Macro undefined, 09:45 AM -> 8 chars 0,9,':',4,5,' ',A,M; no seconds items issued.
